pc_fetch_ctrl: RTL

Fetch sequencer that owns the program counter and instruction-memory chip enable for the MIPS core. It replaces free-running PC increment with a controlled schedule: one fetch outstanding at a time, waits on instruction-memory ready, applies stalls, branch redirects (with delay-slot semantics), pipeline flushes (exception/eret), and halt/resume. It sits between the control unit, the ID stage, and instruction ROM, and feeds the IF/ID register.

---
 rtl/pc_fetch_ctrl_if.sv | 34 +++
 rtl/pc_fetch_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-control bus between the control unit / ID stage / instruction ROM
// and the fetch sequencer.
//   stall_req   : IF/ID cannot accept this cycle
//   br_valid    : branch/jump resolved taken in ID, target on br_target
//   flush_valid : exception entry or eret, target on flush_pc
//   halt_req    : level request to stop fetching
//   imem_ready  : instruction memory returned data for the current pc
//   pc, ce      : fetch address and instruction-memory chip enable
//   inst_valid  : fetch at pc completes and is delivered to IF/ID
// master = requesting side (control/ID/ROM), slave = the fetch sequencer.
interface pc_fetch_ctrl_if;
  logic        stall_req;
  logic        br_valid;
  logic [31:0] br_target;
  logic        flush_valid;
  logic [31:0] flush_pc;
  logic        halt_req;
  logic        imem_ready;
  logic [31:0] pc;
  logic        ce;
  logic        inst_valid;

  modport master (
    output stall_req, br_valid, br_target, flush_valid, flush_pc,
           halt_req, imem_ready,
    input  pc, ce, inst_valid
  );

  modport slave (
    input  stall_req, br_valid, br_target, flush_valid, flush_pc,
           halt_req, imem_ready,
    output pc, ce, inst_valid
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the program counter and instruction-memory chip
// enable. Keeps one fetch outstanding, waits on imem_ready, applies stalls,
// branch redirects with delay-slot semantics, flushes and halt/resume.
// Ports:
//   clk  : system clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : pc_fetch_ctrl_if.slave (redirect/stall/halt inputs, pc/ce/inst_valid)
// RESET_VECTOR is the first fetch address after reset.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  pc_fetch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state;
  logic        pend_valid;
  logic        pend_kill;   // 1 = pending flush, 0 = pending branch
  logic [31:0] pend_pc;
  logic        pend_flush;

  assign pend_flush = pend_valid & pend_kill;

  // Delivery is suppressed whenever the fetched word is about to be
  // discarded (flush now or queued) or IF/ID cannot take it.
  assign bus.inst_valid = (state == FETCH) & bus.imem_ready & ~bus.stall_req &
                          ~bus.flush_valid & ~pend_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bus.pc     <= RESET_VECTOR;
      bus.ce     <= 1'b0;
      pend_valid <= 1'b0;
      pend_kill  <= 1'b0;
      pend_pc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          state  <= FETCH;
          bus.ce <= 1'b1;
        end

        FETCH: begin
          if (!bus.imem_ready) begin
            // Fetch still outstanding: pc frozen, remember the redirect.
            // A queued flush can never be displaced by a later branch.
            if (bus.flush_valid) begin
              pend_valid <= 1'b1;
              pend_kill  <= 1'b1;
              pend_pc    <= bus.flush_pc;
            end else if (bus.br_valid && !bus.stall_req && !pend_flush) begin
              pend_valid <= 1'b1;
              pend_kill  <= 1'b0;
              pend_pc    <= bus.br_target;
            end
          end else begin
            if (bus.flush_valid) begin
              bus.pc     <= bus.flush_pc;
              pend_valid <= 1'b0;
            end else if (pend_flush) begin
              bus.pc     <= pend_pc;
              pend_valid <= 1'b0;
            end else if (bus.stall_req) begin
              // Reissue the same fetch; a pending branch survives the stall.
            end else if (pend_valid) begin
              bus.pc     <= pend_pc;
              pend_valid <= 1'b0;
            end else if (bus.br_valid) begin
              bus.pc <= bus.br_target;
            end else begin
              bus.pc <= bus.pc + 32'd4;
            end

            if (bus.halt_req && !bus.flush_valid) begin
              state  <= HALT;
              bus.ce <= 1'b0;
            end
          end
        end

        HALT: begin
          if (bus.flush_valid) begin
            bus.pc     <= bus.flush_pc;
            pend_valid <= 1'b0;
            state      <= FETCH;
            bus.ce     <= 1'b1;
          end else if (!bus.halt_req) begin
            state  <= FETCH;
            bus.ce <= 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          bus.ce <= 1'b0;
        end
      endcase
    end
  end

endmodule
